// File: rtl/sin_cos_gen.sv
// Eight-lane sine/cosine NCO producing 8 samples per clock at 1.6 GS/s.
// Ports: clk, rst_n (async low), frq (Hz) -> phase_inc_out, 8 sine ports,
//   packed signal_out_sin / signal_out_cos (sample k at [16k+15:16k]), out_valid.
module sin_cos_gen #(
   parameter int AMPLITUDE  = 32767,
   parameter int LUT_ADDR_W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  frq,
   output logic [31:0]  phase_inc_out,
   output logic [15:0]  sin_out_reg_p,
   output logic [15:0]  sin_out_reg_2_p,
   output logic [15:0]  sin_out_reg_3_p,
   output logic [15:0]  sin_out_reg_4_p,
   output logic [15:0]  sin_out_reg_5_p,
   output logic [15:0]  sin_out_reg_6_p,
   output logic [15:0]  sin_out_reg_7_p,
   output logic [15:0]  sin_out_reg_8_p,
   output logic [127:0] signal_out_sin,
   output logic [127:0] signal_out_cos,
   output logic         out_valid
);

   localparam int  LUT_N = 1 << LUT_ADDR_W;
   localparam real PI    = 3.14159265358979323846;

   // 2^64 / 1.6e9, so (frq * K) >> 32 is frq * 2^32 / 1.6e9.
   localparam logic [63:0] K_MUL = 64'd11529215046;
   localparam logic [63:0] RND   = 64'h0000_0000_8000_0000;

   localparam logic [LUT_ADDR_W-1:0] QTR = LUT_ADDR_W'(LUT_N / 4);

   logic signed [15:0] lut [LUT_N];

   // Table is fixed at elaboration; rounding is half away from zero.
   for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      localparam real X = AMPLITUDE * $sin(2.0 * PI * gi / LUT_N);
      localparam int  V = (X >= 0.0) ? $rtoi(X + 0.5) : -$rtoi(0.5 - X);
      assign lut[gi] = V[15:0];
   end

   logic [31:0] frq_r;
   logic [31:0] acc;
   logic [63:0] prod;
   logic [31:0] inc_nxt;
   logic [31:0] ph [8];

   logic [LUT_ADDR_W-1:0] sa [8];
   logic [LUT_ADDR_W-1:0] ca [8];

   logic signed [15:0] sin_r [8];
   logic signed [15:0] cos_r [8];

   logic [3:0] vld_sr;

   // Product is kept mod 2^64; bits above 63 never reach the result.
   assign prod    = {32'd0, frq_r} * K_MUL + RND;
   assign inc_nxt = 32'(prod >> 32);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frq_r         <= '0;
         phase_inc_out <= '0;
         acc           <= '0;
         for (int k = 0; k < 8; k++) ph[k] <= '0;
      end else begin
         frq_r         <= frq;
         phase_inc_out <= inc_nxt;
         // Never cleared on retune: phase stays continuous.
         acc           <= acc + {phase_inc_out[28:0], 3'b000};
         for (int k = 0; k < 8; k++)
            ph[k] <= acc + phase_inc_out * 32'(k);
      end
   end

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         sa[k] = ph[k][31 -: LUT_ADDR_W];
         ca[k] = sa[k] + QTR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            sin_r[k] <= '0;
            cos_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 8; k++) begin
            sin_r[k] <= lut[sa[k]];
            cos_r[k] <= lut[ca[k]];
         end
      end
   end

   // Valid once the pipeline has been filled from reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_sr <= '0;
      else        vld_sr <= {vld_sr[2:0], 1'b1};
   end

   assign out_valid = vld_sr[3];

   for (genvar k = 0; k < 8; k++) begin : g_pack
      assign signal_out_sin[16*k +: 16] = sin_r[k];
      assign signal_out_cos[16*k +: 16] = cos_r[k];
   end

   assign sin_out_reg_p   = sin_r[0];
   assign sin_out_reg_2_p = sin_r[1];
   assign sin_out_reg_3_p = sin_r[2];
   assign sin_out_reg_4_p = sin_r[3];
   assign sin_out_reg_5_p = sin_r[4];
   assign sin_out_reg_6_p = sin_r[5];
   assign sin_out_reg_7_p = sin_r[6];
   assign sin_out_reg_8_p = sin_r[7];

endmodule

// File: tb/tb_sin_cos_gen.sv
// Scoreboard bench for sin_cos_gen: sample-by-sample NCO reference model.
// Stimulus pushes expected increments/phases; a monitor pops and compares.
module tb_sin_cos_gen;

   localparam real PI = 3.14159265358979323846;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [31:0]  frq = '0;
   logic [31:0]  phase_inc_out;
   logic [15:0]  s0, s1, s2, s3, s4, s5, s6, s7;
   logic [127:0] signal_out_sin;
   logic [127:0] signal_out_cos;
   logic         out_valid;

   sin_cos_gen dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .frq            (frq),
      .phase_inc_out  (phase_inc_out),
      .sin_out_reg_p  (s0),
      .sin_out_reg_2_p(s1),
      .sin_out_reg_3_p(s2),
      .sin_out_reg_4_p(s3),
      .sin_out_reg_5_p(s4),
      .sin_out_reg_6_p(s5),
      .sin_out_reg_7_p(s6),
      .sin_out_reg_8_p(s7),
      .signal_out_sin (signal_out_sin),
      .signal_out_cos (signal_out_cos),
      .out_valid      (out_valid)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cnt   = 0;

   logic [31:0]       inc_q [$];
   logic [7:0][31:0]  ph_q  [$];
   logic [31:0]       m_phase = '0;

   // round(f * 2^32 / 1.6e9) via the fixed-point constant, mod 2^32
   function automatic logic [31:0] inc_of(input logic [31:0] f);
      logic [127:0] t;
      t = 128'(f) * 128'd11529215046 + 128'h8000_0000;
      return t[63:32];
   endfunction

   function automatic int lut_ref(input int i);
      real x;
      x = 32767.0 * $sin(2.0 * PI * i / 1024.0);
      if (x >= 0.0) return $rtoi(x + 0.5);
      return -$rtoi(0.5 - x);
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   // Each sample advances the model phase by one increment.
   task automatic push(input logic [31:0] f);
      logic [31:0]      inc;
      logic [7:0][31:0] p;
      inc = inc_of(f);
      inc_q.push_back(inc);
      for (int k = 0; k < 8; k++) begin
         p[k] = m_phase;
         m_phase = m_phase + inc;
      end
      ph_q.push_back(p);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_inc"}, longint'(phase_inc_out), 0);
      chk({tag, "_vld"}, longint'(out_valid), 0);
      chk({tag, "_sin"}, longint'(|signal_out_sin), 0);
      chk({tag, "_cos"}, longint'(|signal_out_cos), 0);
      chk({tag, "_ports"},
          longint'(|{s0, s1, s2, s3, s4, s5, s6, s7}), 0);
   endtask

   task automatic flush();
      inc_q.delete();
      ph_q.delete();
      m_phase = '0;
   endtask

   task automatic reset_neg(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      flush();
      #1 check_zero("rst_async");
      repeat (n) @(negedge clk);
   endtask

   task automatic reset_mid(input int n);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      flush();
      #1 check_zero("rst_mid");
      repeat (n) @(negedge clk);
   endtask

   // Called on a falling edge: release and apply the first frq.
   task automatic release_to(input logic [31:0] f);
      rst_n = 1'b1;
      frq = f;
      push(f);
   endtask

   task automatic run(input logic [31:0] f, input int n);
      repeat (n) begin
         @(negedge clk);
         frq = f;
         push(f);
      end
   endtask

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // Monitor
   initial begin
      logic [15:0]      sp [8];
      logic [7:0][31:0] p;
      int idx;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            cnt = 0;
            check_zero("rst_hold");
         end else begin
            cnt++;
            chk("out_valid", longint'(out_valid), longint'(cnt >= 4));
            if (cnt >= 2) begin
               if (inc_q.size() == 0) chk("inc_q_empty", 1, 0);
               else chk("phase_inc", longint'(phase_inc_out),
                        longint'(inc_q.pop_front()));
            end
            if (cnt >= 4) begin
               if (ph_q.size() == 0) chk("ph_q_empty", 1, 0);
               else begin
                  p = ph_q.pop_front();
                  sp = '{s0, s1, s2, s3, s4, s5, s6, s7};
                  for (int k = 0; k < 8; k++) begin
                     idx = int'(p[k][31:22]);
                     chk($sformatf("sin_port%0d", k), sx(sp[k]),
                         lut_ref(idx));
                     chk($sformatf("sin_pack%0d", k),
                         sx(signal_out_sin[16*k +: 16]), lut_ref(idx));
                     chk($sformatf("cos_pack%0d", k),
                         sx(signal_out_cos[16*k +: 16]),
                         lut_ref((idx + 256) % 1024));
                  end
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [31:0] f;
      rst_n = 1'b0;
      frq = '0;
      #1 check_zero("rst_init");
      repeat (3) @(negedge clk);

      release_to(32'd0);
      run(32'd0, 10);
      chk("idle_sin0", sx(s0), 0);
      chk("idle_cos0", sx(signal_out_cos[15:0]), 32767);
      chk("idle_cos7", sx(signal_out_cos[127:112]), 32767);

      reset_neg(3);
      release_to(32'd200_000_000);
      run(32'd200_000_000, 10);
      chk("inc_200M", longint'(phase_inc_out), longint'(32'h2000_0000));
      chk("f200_s1", sx(s1), 23170);
      chk("f200_s2", sx(s2), 32767);
      chk("f200_s5", sx(s5), -23170);
      chk("f200_s6", sx(s6), -32767);

      run(32'd400_000_000, 10);
      chk("f400_s1", sx(s1), 32767);
      chk("f400_s3", sx(s3), -32767);
      chk("f400_c1", sx(signal_out_cos[31:16]), 0);
      chk("f400_c2", sx(signal_out_cos[47:32]), -32767);

      run(32'd700_000_000, 5);
      chk("inc_700M", longint'(phase_inc_out), longint'(32'h7000_0000));
      run(32'd1_600_000_000, 5);
      chk("inc_1G6", longint'(phase_inc_out), 0);

      reset_neg(2);
      release_to(32'd400_000_000);
      run(32'd400_000_000, 8);
      chk("r400_s5", sx(s5), 32767);
      chk("r400_c4", sx(signal_out_cos[79:64]), 32767);

      repeat (40) begin
         f = $urandom;
         run(f, $urandom_range(1, 6));
      end
      repeat (20) begin
         f = $urandom_range(0, 1_600_000_000);
         run(f, $urandom_range(1, 4));
      end

      run(32'd700_000_000, 6);
      reset_mid(3);
      release_to(32'd700_000_000);
      run(32'd700_000_000, 8);
      chk("mid_inc", longint'(phase_inc_out), longint'(32'h7000_0000));

      run(32'hFFFF_FFFF, 6);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
